// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC widths, constants and FSM state type
package cordic_pkg;

  localparam int CORDIC_W     = 28;
  localparam int CORDIC_ITERS = 28;

  // Q3.W constants (W = 28)
  localparam logic signed [CORDIC_W+2:0] CORDIC_K       = 31'sd163008219;
  localparam logic signed [CORDIC_W+2:0] CORDIC_PI      = 31'sd843314857;
  localparam logic signed [CORDIC_W+2:0] CORDIC_PI_HALF = 31'sd421657428;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_t;

endpackage

// File: rtl/get_radian.sv
// rtl/get_radian.sv - arctangent ROM, atan(2^-addr) in unsigned Q0.W
module get_radian #(
  parameter int W = 28
) (
  input  logic [4:0]   addr,
  output logic [W-1:0] atan
);

  // Table entries are round(atan(2^-i) * 2^28); addresses past the table read zero
  always_comb begin
    atan = '0;
    case (addr)
      5'd0:  atan = W'(210828714);
      5'd1:  atan = W'(124459457);
      5'd2:  atan = W'(65760959);
      5'd3:  atan = W'(33381290);
      5'd4:  atan = W'(16755422);
      5'd5:  atan = W'(8385879);
      5'd6:  atan = W'(4193963);
      5'd7:  atan = W'(2097109);
      5'd8:  atan = W'(1048571);
      5'd9:  atan = W'(524287);
      5'd10: atan = W'(262144);
      5'd11: atan = W'(131072);
      5'd12: atan = W'(65536);
      5'd13: atan = W'(32768);
      5'd14: atan = W'(16384);
      5'd15: atan = W'(8192);
      5'd16: atan = W'(4096);
      5'd17: atan = W'(2048);
      5'd18: atan = W'(1024);
      5'd19: atan = W'(512);
      5'd20: atan = W'(256);
      5'd21: atan = W'(128);
      5'd22: atan = W'(64);
      5'd23: atan = W'(32);
      5'd24: atan = W'(16);
      5'd25: atan = W'(8);
      5'd26: atan = W'(4);
      5'd27: atan = W'(2);
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iterative rotation-mode CORDIC, optional quadrant fold via CORDIC_QUAD_FOLD_EN
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERS = CORDIC_ITERS,
  parameter int W     = CORDIC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W+2:0] angle_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] cos_out,
  output logic signed [W+1:0] sin_out,
  output logic                busy
);

  localparam logic [4:0] LAST_I = 5'(ITERS - 1);

  cordic_state_t       state;
  logic [4:0]          i;
  logic signed [W+1:0] x;
  logic signed [W+1:0] y;
  logic signed [W+2:0] z;

  logic [W-1:0]        atan_raw;
  logic signed [W+2:0] atan_ext;
  logic signed [W+1:0] x_sh;
  logic signed [W+1:0] y_sh;
  logic signed [W+1:0] x_nxt;
  logic signed [W+1:0] y_nxt;
  logic signed [W+2:0] z_nxt;
  logic signed [W+2:0] z_init;

  // ROM is addressed directly by the iteration counter
  get_radian #(.W(W)) u_atan (
    .addr (i),
    .atan (atan_raw)
  );

  // One micro-rotation: direction follows the sign of the residual angle
  always_comb begin
    atan_ext = {3'b000, atan_raw};
    x_sh     = x >>> i;
    y_sh     = y >>> i;
    if (!z[W+2]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_ext;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_ext;
    end
  end

`ifdef CORDIC_QUAD_FOLD_EN
  localparam logic signed [W+2:0] PI_W      = CORDIC_PI[W+2:0];
  localparam logic signed [W+2:0] PI_HALF_W = CORDIC_PI_HALF[W+2:0];

  logic neg;
  logic neg_init;

  // Fold outer quadrants into the convergence range; result is negated later
  always_comb begin
    z_init   = angle_in;
    neg_init = 1'b0;
    if (angle_in > PI_HALF_W) begin
      z_init   = angle_in - PI_W;
      neg_init = 1'b1;
    end else if (angle_in < -PI_HALF_W) begin
      z_init   = angle_in + PI_W;
      neg_init = 1'b1;
    end
  end

  // Drive results only while valid, undoing the fold when it was applied
  always_comb begin
    cos_out = '0;
    sin_out = '0;
    if (out_valid) begin
      cos_out = neg ? -x : x;
      sin_out = neg ? -y : y;
    end
  end
`else
  // Angle enters the datapath unchanged
  always_comb begin
    z_init = angle_in;
  end

  // Drive results only while valid
  always_comb begin
    cos_out = '0;
    sin_out = '0;
    if (out_valid) begin
      cos_out = x;
      sin_out = y;
    end
  end
`endif

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      i         <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef CORDIC_QUAD_FOLD_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x        <= (W+2)'(CORDIC_K);
            y        <= '0;
            z        <= z_init;
            i        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_ITER;
`ifdef CORDIC_QUAD_FOLD_EN
            neg      <= neg_init;
`endif
          end
        end
        ST_ITER: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          if (i == LAST_I) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            i <= i + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
